// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants and arbiter state type for the piano key front-end
// Contents:
//   CLK_HZ           system clock frequency
//   DEFAULT_DEBOUNCE debounce hold time in clk cycles (10 ms at 50 MHz)
//   DEFAULT_NUM_KEYS default number of keys/notes
//   ks_state_t       mono arbiter state (KS_IDLE, KS_HOLD)
package piano_pkg;

  localparam int CLK_HZ           = 50000000;
  localparam int DEFAULT_DEBOUNCE = 500000;
  localparam int DEFAULT_NUM_KEYS = 8;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_HOLD = 1'b1
  } ks_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-FF synchroniser, optional inversion, debouncer, edge pulses
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   raw           raw asynchronous sensor input
//   stable        debounced level
//   accept_rise   combinational: stable rises on the coming edge
//   accept_fall   combinational: stable falls on the coming edge
//   press_pulse   registered one-cycle strobe, first cycle stable is high
//   release_pulse registered one-cycle strobe, first cycle stable is low
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int SENSE_INV       = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic accept_rise,
  output logic accept_fall,
  output logic press_pulse,
  output logic release_pulse
);

  logic        s1;
  logic        s2;
  logic        lvl;
  logic        accept;
  logic [23:0] cnt;

  assign lvl = (SENSE_INV != 0) ? ~s2 : s2;

  // The accept strobes are exported ahead of the edge so the mono arbiter
  // can move on the same edge that stable changes.
  assign accept      = (lvl != stable) && (cnt == 24'(DEBOUNCE_CYCLES - 1));
  assign accept_rise = accept & lvl;
  assign accept_fall = accept & ~lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      stable        <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      press_pulse   <= accept_rise;
      release_pulse <= accept_fall;
      // Any cycle agreeing with stable restarts the count, so each bounce
      // begins a fresh hold interval.
      if (lvl == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= lvl;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 24'd1;
      end
    end
  end

endmodule

// File: rtl/key_sense.sv
// rtl/key_sense.sv - piano key front-end: per-key debounce plus optional mono last-pressed arbiter
// Build option: KEY_SENSE_MONO_EN defined -> mono arbiter (at most one key sounds);
//               undefined -> light is the debounced vector (chords allowed).
// Ports:
//   clk           system clock (50 MHz)
//   rst           asynchronous active-low reset
//   sense_raw     raw asynchronous sensor inputs, one per key
//   light         key levels to the sound generators
//   press_pulse   one-cycle strobe per debounced rising edge
//   release_pulse one-cycle strobe per debounced falling edge
//   any_key       a key is sounding
//   key_index     index of the sounding key (lowest held key when not mono), 0 when none
module key_sense
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int SENSE_INV       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         sense_raw,
  output logic [NUM_KEYS-1:0]         light,
  output logic [NUM_KEYS-1:0]         press_pulse,
  output logic [NUM_KEYS-1:0]         release_pulse,
  output logic                        any_key,
  output logic [$clog2(NUM_KEYS)-1:0] key_index
);

  localparam int IW = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  function automatic logic [IW-1:0] low_idx(input logic [NUM_KEYS-1:0] v);
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) low_idx = IW'(i);
    end
  endfunction

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SENSE_INV      (SENSE_INV)
    ) u_deb (
      .clk          (clk),
      .rst          (rst),
      .raw          (sense_raw[k]),
      .stable       (stable[k]),
      .accept_rise  (rise[k]),
      .accept_fall  (fall[k]),
      .press_pulse  (press_pulse[k]),
      .release_pulse(release_pulse[k])
    );
  end

`ifdef KEY_SENSE_MONO_EN

  ks_state_t           state;
  ks_state_t           state_nx;
  logic [IW-1:0]       cur;
  logic [IW-1:0]       cur_nx;
  logic [NUM_KEYS-1:0] stable_nx;

  // Value stable takes on the coming edge.
  assign stable_nx = (stable & ~fall) | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= KS_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    case (state)
      KS_IDLE: begin
        if (|rise) begin
          state_nx = KS_HOLD;
          cur_nx   = low_idx(rise);
        end
      end
      KS_HOLD: begin
        // A new press is checked first so it beats a release of cur on the same edge.
        if (|rise) begin
          cur_nx = low_idx(rise);
        end else if (fall[cur]) begin
          if (|stable_nx) begin
            cur_nx = low_idx(stable_nx);
          end else begin
            state_nx = KS_IDLE;
            cur_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = KS_IDLE;
        cur_nx   = '0;
      end
    endcase
  end

  always_comb begin
    light = '0;
    if (state == KS_HOLD) light[cur] = 1'b1;
  end

  assign any_key   = (state == KS_HOLD);
  assign key_index = (state == KS_HOLD) ? cur : '0;

`else

  logic unused_accept;
  assign unused_accept = ^{rise, fall};

  assign light     = stable;
  assign any_key   = |stable;
  assign key_index = low_idx(stable);

`endif

endmodule
